// File: rtl/uart_pkt_decoder_if.sv
// Byte-stream bundle between uart_rx, the packet decoder and its downstream consumer.
// master drives received bytes and out_ready; slave is the decoder.
interface uart_pkt_decoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, pkt_ok, pkt_err, err_code
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, pkt_ok, pkt_err, err_code
  );
endinterface

// File: rtl/uart_pkt_decoder.sv
// Store-and-forward decoder for SYNC/LEN/payload/XOR-checksum frames from uart_rx.
// Only checksum-clean payloads are replayed downstream; bad or stalled frames are dropped.
module uart_pkt_decoder #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC           = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  uart_pkt_decoder_if.slave bus
);

  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TO  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] to_cnt;
  logic [7:0]       len_r;
  logic [7:0]       chk;
  logic [7:0]       pay_buf [MAX_LEN];

  logic       out_valid_r;
  logic       out_last_r;
  logic [7:0] out_data_r;
  logic       pkt_ok_r;
  logic       pkt_err_r;
  logic [1:0] err_code_r;

  logic             accept;
  logic             xfer;
  logic             in_pkt;
  logic             timeout_hit;
  logic             len_bad;
  logic             idx_at_end;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       len_m1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TO_MAX) ? TO_MAX : v + CNT_ONE;
  endfunction

  assign bus.in_ready = (state != ST_DRAIN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_r && bus.out_ready;
  assign in_pkt       = state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
  // A byte accepted on the deadline edge wins over the timeout.
  assign timeout_hit  = in_pkt && !accept && (to_cnt == TO_LAST);
  assign len_bad      = (bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B);
  assign len_m1       = len_r - 8'd1;
  assign idx_at_end   = (8'(idx) == len_m1);
  assign idx_nxt      = idx + IDX_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      to_cnt      <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 8'd0;
      pkt_ok_r    <= 1'b0;
      pkt_err_r   <= 1'b0;
      err_code_r  <= 2'd0;
    end else begin
      pkt_ok_r   <= 1'b0;
      pkt_err_r  <= 1'b0;
      err_code_r <= 2'd0;
      case (state)
        ST_IDLE: begin
          if (accept && bus.in_data == SYNC) begin
            to_cnt <= '0;
            state  <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept) begin
            to_cnt <= '0;
            if (len_bad) begin
              pkt_err_r  <= 1'b1;
              err_code_r <= ERR_LEN;
              state      <= ST_IDLE;
            end else begin
              idx   <= '0;
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            to_cnt <= '0;
            if (idx_at_end) state <= ST_CHK;
            else            idx   <= idx_nxt;
          end
        end
        ST_CHK: begin
          if (accept) begin
            to_cnt <= '0;
            if (bus.in_data == chk) begin
              pkt_ok_r    <= 1'b1;
              idx         <= '0;
              out_valid_r <= 1'b1;
              out_data_r  <= pay_buf[0];
              out_last_r  <= (len_r == 8'd1);
              state       <= ST_DRAIN;
            end else begin
              pkt_err_r  <= 1'b1;
              err_code_r <= ERR_CHK;
              state      <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (out_last_r) begin
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= 8'd0;
              state       <= ST_IDLE;
            end else begin
              idx        <= idx_nxt;
              out_data_r <= pay_buf[idx_nxt];
              out_last_r <= (8'(idx_nxt) == len_m1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Idle-gap watchdog shared by every in-packet state; overrides the case above.
      if (timeout_hit) begin
        pkt_err_r  <= 1'b1;
        err_code_r <= ERR_TO;
        state      <= ST_IDLE;
        to_cnt     <= sat_inc(to_cnt);
      end else if (in_pkt && !accept) begin
        to_cnt <= sat_inc(to_cnt);
      end
    end
  end

  // Payload store, length and running checksum carry no reset; state gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        ST_LEN: begin
          len_r <= bus.in_data;
          chk   <= bus.in_data;
        end
        ST_PAYLOAD: begin
          pay_buf[idx] <= bus.in_data;
          chk          <= chk ^ bus.in_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_data  = out_data_r;
  assign bus.pkt_ok    = pkt_ok_r;
  assign bus.pkt_err   = pkt_err_r;
  assign bus.err_code  = err_code_r;

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Directed and randomized bench for uart_pkt_decoder against a frame-level reference model.
module tb_uart_pkt_decoder;
  localparam int         MAXL = 16;
  localparam int         TMO  = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  uart_pkt_decoder_if bus();

  uart_pkt_decoder #(
    .MAX_LEN(MAXL),
    .SYNC(SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  // Output bytes as {last, data}; events: 4 = pkt_ok, otherwise {0, err_code}.
  logic [8:0] obs_b[$];
  logic [8:0] exp_b[$];
  logic [2:0] obs_ev[$];
  logic [2:0] exp_ev[$];
  logic [7:0] pq[$];
  logic       rnd_rdy = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_valid || {bus.out_last, bus.out_data} !== prev_out)) viol++;
      if (bus.out_valid && bus.in_ready) viol++;
      if (bus.pkt_ok && bus.pkt_err) viol++;
      if (!bus.pkt_err && bus.err_code != 2'd0) viol++;
      if (bus.out_valid && bus.out_ready) obs_b.push_back({bus.out_last, bus.out_data});
      if (bus.pkt_ok) obs_ev.push_back(3'd4);
      if (bus.pkt_err) obs_ev.push_back({1'b0, bus.err_code});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_last, bus.out_data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frames are collected whole, then judged by length and XOR rules.
  task automatic model_gap(input int g);
    if (pq.size() > 0 && g >= TMO) begin
      exp_ev.push_back(3'd3);
      pq.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int g);
    logic [7:0] x;
    model_gap(g);
    if (pq.size() == 0) begin
      if (b == SYNC) pq.push_back(b);
    end else if (pq.size() == 1) begin
      if (b == 8'd0 || int'(b) > MAXL) begin
        exp_ev.push_back(3'd2);
        pq.delete();
      end else begin
        pq.push_back(b);
      end
    end else if (pq.size() < int'(pq[1]) + 2) begin
      pq.push_back(b);
    end else begin
      x = 8'd0;
      for (int i = 1; i < pq.size(); i++) x ^= pq[i];
      if (x == b) begin
        exp_ev.push_back(3'd4);
        for (int i = 2; i < pq.size(); i++) exp_b.push_back({i == pq.size() - 1, pq[i]});
      end else begin
        exp_ev.push_back(3'd1);
      end
      pq.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] b, input int g);
    logic acc;
    int   n;
    bus.in_valid = 1'b0;
    repeat (g) step();
    model_byte(b, g);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      acc = bus.in_ready;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic settle();
    int n;
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 300) begin
      step();
      n++;
    end
    chk("settle_drain", 32'(bus.out_valid), 32'd0);
    repeat (TMO + 4) step();
    model_gap(TMO + 4);
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s:nbytes", tag), obs_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      chk($sformatf("%s:byte%0d", tag, i), 32'(obs_b[i]), 32'(exp_b[i]));
    chk($sformatf("%s:nevents", tag), obs_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
      chk($sformatf("%s:event%0d", tag, i), 32'(obs_ev[i]), 32'(exp_ev[i]));
    chk($sformatf("%s:protocol", tag), viol, 0);
    obs_b.delete();
    exp_b.delete();
    obs_ev.delete();
    exp_ev.delete();
    viol = 0;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 2));
  endfunction

  task automatic rand_packet();
    int         kind;
    int         len;
    int         k;
    logic [7:0] x;
    logic [7:0] b;
    kind = $urandom_range(0, 5);
    case (kind)
      0, 1, 2: begin
        len = $urandom_range(1, MAXL);
        send(SYNC, rgap());
        x = 8'(len);
        send(8'(len), rgap());
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          x ^= b;
          send(b, rgap());
        end
        if (kind == 2) x ^= 8'($urandom_range(1, 255));
        send(x, rgap());
      end
      3: begin
        send(SYNC, rgap());
        send(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255)), rgap());
      end
      4: begin
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) send(8'($urandom), rgap());
      end
      default: begin
        len = $urandom_range(2, MAXL);
        send(SYNC, rgap());
        send(8'(len), rgap());
        k = $urandom_range(0, len - 1);
        for (int i = 0; i < k; i++) send(8'($urandom), rgap());
        k = TMO + $urandom_range(0, 5);
        repeat (k) step();
        model_gap(k);
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] x;

    // Reset: a SYNC offered during reset must not be taken.
    rst = 1'b1;
    bus.in_data   = SYNC;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    chk("rst_pkt_err", 32'(bus.pkt_err), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h03, 0);
    settle();
    compare("rst_no_accept");

    // Good packet.
    send(SYNC, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h03, 0);
    chk("good_pkt_ok", 32'(bus.pkt_ok), 32'd1);
    chk("good_first_valid", 32'(bus.out_valid), 32'd1);
    chk("good_first_data", 32'(bus.out_data), 32'h11);
    chk("good_in_ready", 32'(bus.in_ready), 32'd0);
    settle();
    compare("good");

    // Bad checksum, then a good packet.
    send(SYNC, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h00, 0);
    chk("badchk_err", 32'(bus.pkt_err), 32'd1);
    chk("badchk_code", 32'(bus.err_code), 32'd1);
    chk("badchk_valid", 32'(bus.out_valid), 32'd0);
    chk("badchk_in_ready", 32'(bus.in_ready), 32'd1);
    send(SYNC, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h03, 0);
    settle();
    compare("badchk");

    // Illegal lengths, then a one-byte packet whose payload is SYNC.
    send(SYNC, 0); send(8'h00, 0);
    chk("len0_code", 32'(bus.err_code), 32'd2);
    send(SYNC, 0); send(8'h11, 0);
    chk("len17_code", 32'(bus.err_code), 32'd2);
    send(SYNC, 0); send(8'h01, 0); send(8'hA5, 0); send(8'hA4, 0);
    settle();
    compare("badlen");

    // Noise then a full-buffer packet under backpressure.
    bus.out_ready = 1'b0;
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    send(SYNC, 0); send(8'h10, 0);
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 0);
      x ^= 8'(i);
    end
    send(x, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'h00);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    settle();
    compare("backpressure");

    // Timeout exactly TMO cycles after the last accepted byte.
    send(SYNC, 0); send(8'h02, 0); send(8'h11, 0);
    n = 0;
    while (n < 2 * TMO && !bus.pkt_err) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_code", 32'(bus.err_code), 32'd3);
    model_gap(n);
    send(SYNC, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, TMO - 1);
    send(8'h02 ^ 8'h11 ^ 8'h22, 0);
    settle();
    compare("timeout");

    // Reset while the second of three bytes is pending.
    bus.out_ready = 1'b0;
    send(SYNC, 0); send(8'h03, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    send(8'h03 ^ 8'hAA ^ 8'hBB ^ 8'hCC, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pend_data", 32'(bus.out_data), 32'hBB);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    chk("mid_rst_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    step();
    rst = 1'b0;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    void'(exp_b.pop_back());
    void'(exp_b.pop_back());
    bus.out_ready = 1'b1;
    repeat (5) step();
    compare("reset_drain");
    send(SYNC, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h5B, 0);
    settle();
    compare("post_reset");

    // Randomized frame mix with random downstream stalls.
    rnd_rdy = 1'b1;
    repeat (40) rand_packet();
    settle();
    compare("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
